// File: rtl/gmii_arbi_pkg.sv
// Shared speed codes, FSM state type and default tick constants for the GMII speed arbiter.
package gmii_arbi_pkg;

    localparam logic [1:0] SPD_10   = 2'b00;
    localparam logic [1:0] SPD_100  = 2'b01;
    localparam logic [1:0] SPD_1000 = 2'b10;
    localparam logic [1:0] SPD_RSVD = 2'b11;

    localparam int unsigned DEF_TICKS_1000 = 32'd125_000_000;
    localparam int unsigned DEF_TICKS_100  = 32'd25_000_000;
    localparam int unsigned DEF_TICKS_10   = 32'd2_500_000;

    localparam int CNT_W = 16;

    typedef enum logic [1:0] {
        ST_PHY_RST = 2'd0,
        ST_RUN     = 2'd1,
        ST_SETTLE  = 2'd2,
        ST_DRAIN   = 2'd3
    } arbi_state_t;

    // The reserved code is never adopted as a mode; the PHY falls back to 10M.
    function automatic logic [1:0] accept_speed(input logic [1:0] code);
        return (code == SPD_RSVD) ? SPD_10 : code;
    endfunction

endpackage

// File: rtl/gmii_sync.sv
// Multi-flop synchroniser for asynchronous PHY status inputs (STAGES >= 2).
module gmii_sync #(
    parameter int STAGES = 3,
    parameter int W      = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout
);

    logic [STAGES-1:0][W-1:0] chain;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            chain <= '0;
        end else begin
            chain <= {chain[STAGES-2:0], din};
        end
    end

    assign dout = chain[STAGES-1];

endmodule

// File: rtl/gmii_speed_arbi.sv
// GMII speed arbiter: accepts stable PHY speed changes, pulses the PHY reset between
// modes and muxes the 1000M / 10-100M datapaths. Option: GMII_SPEED_ARBI_LINKDOWN_RST_EN.
module gmii_speed_arbi
    import gmii_arbi_pkg::*;
#(
    parameter int          DATA_W      = 8,
    parameter int          SYNC_STAGES = 3,
    parameter int          STABLE_CYC  = 64,
    parameter int          RST_CYC     = 200,
    parameter int unsigned TICKS_1000  = DEF_TICKS_1000,
    parameter int unsigned TICKS_100   = DEF_TICKS_100,
    parameter int unsigned TICKS_10    = DEF_TICKS_10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        speed,
    input  logic              link,
    input  logic              gmii_rx_dv_r,
    input  logic [DATA_W-1:0] gmii_rxd_r,
    input  logic              gmii_tx_en,
    input  logic [DATA_W-1:0] gmii_txd,
    input  logic              e10_100_rx_dv,
    input  logic [DATA_W-1:0] e10_100_rxd,
    input  logic              e10_100_tx_en,
    input  logic [DATA_W-1:0] e10_100_txd,
    output logic              rx_dv_raw,
    output logic [DATA_W-1:0] rxd_raw,
    output logic              eth_1000m_en,
    output logic              eth_100m_en,
    output logic              eth_10m_en,
    output logic [31:0]       pack_total_len,
    output logic              e_rst_n,
    output logic              e_rx_dv,
    output logic [DATA_W-1:0] e_rxd,
    output logic              e_tx_en_r,
    output logic [DATA_W-1:0] e_txd_r
);

    localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(RST_CYC - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYC - 1);

    function automatic logic [CNT_W-1:0] cnt_sat_inc(input logic [CNT_W-1:0] c);
        return (c == {CNT_W{1'b1}}) ? c : c + 1'b1;
    endfunction

    arbi_state_t      state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [1:0]       spd_cur, spd_cur_nxt;
    logic [1:0]       spd_seen;
    logic [1:0]       spd_sync;
    logic             link_sync;
    logic             path_on;

    logic              tx_en_p0;
    logic [DATA_W-1:0] txd_p0;
    logic              e10_tx_en_p0;
    logic [DATA_W-1:0] e10_txd_p0;

    gmii_sync #(
        .STAGES (SYNC_STAGES),
        .W      (2)
    ) u_speed_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (speed),
        .dout  (spd_sync)
    );

    gmii_sync #(
        .STAGES (SYNC_STAGES),
        .W      (1)
    ) u_link_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (link),
        .dout  (link_sync)
    );

`ifdef GMII_SPEED_ARBI_LINKDOWN_RST_EN
    logic link_prev;
    logic link_fall;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            link_prev <= 1'b0;
        end else begin
            link_prev <= link_sync;
        end
    end

    assign link_fall = link_prev & ~link_sync;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= ST_PHY_RST;
            cnt      <= '0;
            spd_cur  <= SPD_10;
            spd_seen <= SPD_10;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            spd_cur  <= spd_cur_nxt;
            spd_seen <= spd_sync;
        end
    end

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        spd_cur_nxt = spd_cur;
        case (state)
            ST_PHY_RST: begin
                cnt_nxt = cnt_sat_inc(cnt);
                if (cnt >= RST_LAST) begin
                    state_nxt   = ST_RUN;
                    cnt_nxt     = '0;
                    spd_cur_nxt = accept_speed(spd_sync);
                end
            end
            ST_RUN: begin
                cnt_nxt = '0;
                if (spd_sync != spd_cur && spd_sync != SPD_RSVD) begin
                    state_nxt = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                // A return to the current mode, or the reserved code, abandons the switch.
                if (spd_sync == spd_cur || spd_sync == SPD_RSVD) begin
                    state_nxt = ST_RUN;
                    cnt_nxt   = '0;
                end else if (spd_sync != spd_seen) begin
                    cnt_nxt = '0;
                end else if (cnt >= STABLE_LAST) begin
                    state_nxt = ST_DRAIN;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt_sat_inc(cnt);
                end
            end
            ST_DRAIN: begin
                cnt_nxt = '0;
                if (!rx_dv_raw && !gmii_tx_en) begin
                    state_nxt = ST_PHY_RST;
                end
            end
            default: begin
                state_nxt = ST_PHY_RST;
                cnt_nxt   = '0;
            end
        endcase
`ifdef GMII_SPEED_ARBI_LINKDOWN_RST_EN
        if (state != ST_PHY_RST && link_fall) begin
            state_nxt = ST_PHY_RST;
            cnt_nxt   = '0;
        end
`endif
    end

    assign path_on = (state != ST_PHY_RST);

    always_comb begin
        eth_1000m_en   = 1'b0;
        eth_100m_en    = 1'b0;
        eth_10m_en     = 1'b0;
        pack_total_len = TICKS_10;
        if (path_on) begin
            case (spd_cur)
                SPD_1000: begin
                    eth_1000m_en   = 1'b1;
                    pack_total_len = TICKS_1000;
                end
                SPD_100: begin
                    eth_100m_en    = 1'b1;
                    pack_total_len = TICKS_100;
                end
                default: begin
                    eth_10m_en     = 1'b1;
                    pack_total_len = TICKS_10;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_dv_raw    <= 1'b0;
            rxd_raw      <= '0;
            tx_en_p0     <= 1'b0;
            txd_p0       <= '0;
            e10_tx_en_p0 <= 1'b0;
            e10_txd_p0   <= '0;
            e_rx_dv      <= 1'b0;
            e_rxd        <= '0;
            e_tx_en_r    <= 1'b0;
            e_txd_r      <= '0;
            e_rst_n      <= 1'b0;
        end else begin
            // stage p0: capture raw PHY receive and both transmit sources
            rx_dv_raw    <= gmii_rx_dv_r;
            rxd_raw      <= gmii_rxd_r;
            tx_en_p0     <= gmii_tx_en;
            txd_p0       <= gmii_txd;
            e10_tx_en_p0 <= e10_100_tx_en;
            e10_txd_p0   <= e10_100_txd;
            // stage p1: mode mux into the output registers; gated by the current
            // state so the final byte clocked out of DRAIN still reaches the pins
            if (spd_cur == SPD_1000) begin
                e_rx_dv   <= rx_dv_raw & path_on;
                e_rxd     <= rxd_raw;
                e_tx_en_r <= tx_en_p0 & path_on;
                e_txd_r   <= txd_p0;
            end else begin
                e_rx_dv   <= e10_100_rx_dv & path_on;
                e_rxd     <= e10_100_rxd;
                e_tx_en_r <= e10_tx_en_p0 & path_on;
                e_txd_r   <= e10_txd_p0;
            end
            e_rst_n <= link_sync & (state_nxt != ST_PHY_RST);
        end
    end

endmodule

// File: tb/tb_gmii_speed_arbi.sv
// Scoreboard bench for gmii_speed_arbi: random traffic, speed switching, glitch,
// reserved code, drain, link and mid-frame reset scenarios.
module tb_gmii_speed_arbi;

    localparam int DW          = 8;
    localparam int SYNC_STAGES = 3;
    localparam int STABLE_CYC  = 64;
    localparam int RST_CYC     = 200;
    localparam int unsigned T1000 = 125000000;
    localparam int unsigned T100  = 25000000;
    localparam int unsigned T10   = 2500000;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [1:0]    speed = 2'b10;
    logic          link = 1'b1;
    logic          gmii_rx_dv_r = 1'b0;
    logic [DW-1:0] gmii_rxd_r = '0;
    logic          gmii_tx_en = 1'b0;
    logic [DW-1:0] gmii_txd = '0;
    logic          e10_100_rx_dv = 1'b0;
    logic [DW-1:0] e10_100_rxd = '0;
    logic          e10_100_tx_en = 1'b0;
    logic [DW-1:0] e10_100_txd = '0;
    logic          rx_dv_raw;
    logic [DW-1:0] rxd_raw;
    logic          eth_1000m_en, eth_100m_en, eth_10m_en;
    logic [31:0]   pack_total_len;
    logic          e_rst_n;
    logic          e_rx_dv;
    logic [DW-1:0] e_rxd;
    logic          e_tx_en_r;
    logic [DW-1:0] e_txd_r;

    gmii_speed_arbi #(
        .DATA_W      (DW),
        .SYNC_STAGES (SYNC_STAGES),
        .STABLE_CYC  (STABLE_CYC),
        .RST_CYC     (RST_CYC),
        .TICKS_1000  (T1000),
        .TICKS_100   (T100),
        .TICKS_10    (T10)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .speed          (speed),
        .link           (link),
        .gmii_rx_dv_r   (gmii_rx_dv_r),
        .gmii_rxd_r     (gmii_rxd_r),
        .gmii_tx_en     (gmii_tx_en),
        .gmii_txd       (gmii_txd),
        .e10_100_rx_dv  (e10_100_rx_dv),
        .e10_100_rxd    (e10_100_rxd),
        .e10_100_tx_en  (e10_100_tx_en),
        .e10_100_txd    (e10_100_txd),
        .rx_dv_raw      (rx_dv_raw),
        .rxd_raw        (rxd_raw),
        .eth_1000m_en   (eth_1000m_en),
        .eth_100m_en    (eth_100m_en),
        .eth_10m_en     (eth_10m_en),
        .pack_total_len (pack_total_len),
        .e_rst_n        (e_rst_n),
        .e_rx_dv        (e_rx_dv),
        .e_rxd          (e_rxd),
        .e_tx_en_r      (e_tx_en_r),
        .e_txd_r        (e_txd_r)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [DW-1:0] d;
        int            due;
    } exp_t;

    exp_t txq[$];
    exp_t rxq[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    bit   mon_on = 1'b0;
    int   low_cnt = 0;
    int   en_bad_cnt = 0;
    logic [2:0] watch_en = 3'b000;

    // Reference: mode enables and tick counts per accepted speed code.
    function automatic logic [2:0] en_of(input logic [1:0] s);
        if (s == 2'b10) return 3'b100;
        if (s == 2'b01) return 3'b010;
        return 3'b001;
    endfunction

    function automatic logic [31:0] ticks_of(input logic [1:0] s);
        if (s == 2'b10) return T1000;
        if (s == 2'b01) return T100;
        return T10;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic chk_rng(input string nm, input int act, input int lo, input int hi);
        n_cmp++;
        if (act < lo || act > hi) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d..%0d", nm, act, lo, hi);
        end
    endtask

    task automatic chk_mode(input string tag, input logic [1:0] s);
        chk($sformatf("%s_enables", tag), 64'({eth_1000m_en, eth_100m_en, eth_10m_en}), 64'(en_of(s)));
        chk($sformatf("%s_ticks", tag), 64'(pack_total_len), 64'(ticks_of(s)));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        gmii_rx_dv_r  = 1'b0; gmii_rxd_r  = '0;
        gmii_tx_en    = 1'b0; gmii_txd    = '0;
        e10_100_rx_dv = 1'b0; e10_100_rxd = '0;
        e10_100_tx_en = 1'b0; e10_100_txd = '0;
    endtask

    task automatic wait_rst(input logic lvl, input int max, output int at);
        at = -1;
        for (int i = 0; i < max; i++) begin
            tick();
            if (e_rst_n === lvl) begin
                at = cyc;
                return;
            end
        end
    endtask

    // Random traffic on the selected path, noise on the other; expected bytes are
    // queued with the cycle at which they must appear on the outputs.
    task automatic traffic(input bit gig, input int n, input bit idle_end);
        for (int i = 0; i < n; i++) begin
            logic          t_en, r_en;
            logic [DW-1:0] td, rd;
            t_en = 1'($urandom_range(0, 3) != 0);
            r_en = 1'($urandom_range(0, 3) != 0);
            td   = DW'($urandom);
            rd   = DW'($urandom);
            if (gig) begin
                gmii_tx_en = t_en; gmii_txd = td;
                gmii_rx_dv_r = r_en; gmii_rxd_r = rd;
                e10_100_tx_en = 1'($urandom_range(0, 1)); e10_100_txd = DW'($urandom);
                e10_100_rx_dv = 1'($urandom_range(0, 1)); e10_100_rxd = DW'($urandom);
                if (t_en) txq.push_back('{d: td, due: cyc + 2});
                if (r_en) rxq.push_back('{d: rd, due: cyc + 2});
            end else begin
                e10_100_tx_en = t_en; e10_100_txd = td;
                e10_100_rx_dv = r_en; e10_100_rxd = rd;
                gmii_tx_en = 1'($urandom_range(0, 1)); gmii_txd = DW'($urandom);
                gmii_rx_dv_r = 1'($urandom_range(0, 1)); gmii_rxd_r = DW'($urandom);
                if (t_en) txq.push_back('{d: td, due: cyc + 2});
                if (r_en) rxq.push_back('{d: rd, due: cyc + 1});
            end
            tick();
        end
        if (idle_end) begin
            idle();
            repeat (4) tick();
        end
    endtask

    task automatic do_switch(input logic [1:0] s, input string tag);
        int c0, tf, tr;
        c0 = cyc;
        speed = s;
        wait_rst(1'b0, SYNC_STAGES + STABLE_CYC + 10, tf);
        chk_rng($sformatf("%s_switch_delay", tag), tf - c0, SYNC_STAGES + STABLE_CYC, SYNC_STAGES + STABLE_CYC + 3);
        chk($sformatf("%s_phy_rst_enables", tag), 64'({eth_1000m_en, eth_100m_en, eth_10m_en}), 64'(0));
        chk($sformatf("%s_phy_rst_ticks", tag), 64'(pack_total_len), 64'(T10));
        wait_rst(1'b1, RST_CYC + 10, tr);
        chk($sformatf("%s_phy_rst_len", tag), 64'(tr - tf), 64'(RST_CYC));
        chk_mode(tag, s);
    endtask

    // Scoreboard monitor: pops an expected byte whenever the DUT presents one.
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (mon_on) begin
                while (txq.size() > 0 && txq[0].due < cyc) begin
                    n_cmp++; n_bad++;
                    $display("FAIL tx_missing: byte %0h due at cycle %0d not seen by %0d", txq[0].d, txq[0].due, cyc);
                    void'(txq.pop_front());
                end
                while (rxq.size() > 0 && rxq[0].due < cyc) begin
                    n_cmp++; n_bad++;
                    $display("FAIL rx_missing: byte %0h due at cycle %0d not seen by %0d", rxq[0].d, rxq[0].due, cyc);
                    void'(rxq.pop_front());
                end
                if (e_tx_en_r === 1'b1) begin
                    n_cmp++;
                    if (txq.size() == 0) begin
                        n_bad++;
                        $display("FAIL tx_extra: e_txd_r=%0h at cycle %0d, nothing expected", e_txd_r, cyc);
                    end else begin
                        e = txq.pop_front();
                        if (e_txd_r !== e.d || cyc != e.due) begin
                            n_bad++;
                            $display("FAIL tx_byte: got %0h at cycle %0d, expected %0h at cycle %0d", e_txd_r, cyc, e.d, e.due);
                        end
                    end
                end
                if (e_rx_dv === 1'b1) begin
                    n_cmp++;
                    if (rxq.size() == 0) begin
                        n_bad++;
                        $display("FAIL rx_extra: e_rxd=%0h at cycle %0d, nothing expected", e_rxd, cyc);
                    end else begin
                        e = rxq.pop_front();
                        if (e_rxd !== e.d || cyc != e.due) begin
                            n_bad++;
                            $display("FAIL rx_byte: got %0h at cycle %0d, expected %0h at cycle %0d", e_rxd, cyc, e.d, e.due);
                        end
                    end
                end
            end
            if (e_rst_n !== 1'b1) low_cnt++;
            if ({eth_1000m_en, eth_100m_en, eth_10m_en} !== watch_en) en_bad_cnt++;
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation exceeded its cycle budget at cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int rel, t, c0, low0, en0, fall, c_last;
        idle();
        repeat (5) tick();
        chk("reset_e_rst_n", 64'(e_rst_n), 64'(0));
        chk("reset_enables", 64'({eth_1000m_en, eth_100m_en, eth_10m_en}), 64'(0));
        chk("reset_ticks", 64'(pack_total_len), 64'(T10));
        chk("reset_e_rx_dv", 64'(e_rx_dv), 64'(0));
        chk("reset_e_tx_en_r", 64'(e_tx_en_r), 64'(0));
        chk("reset_rx_dv_raw", 64'(rx_dv_raw), 64'(0));
        chk("reset_rxd_raw", 64'(rxd_raw), 64'(0));
        mon_on = 1'b1;

        // Bring-up at 1000M
        rel = cyc;
        rst_n = 1'b1;
        tick();
        chk("bringup_phy_rst_enables", 64'({eth_1000m_en, eth_100m_en, eth_10m_en}), 64'(0));
        wait_rst(1'b1, RST_CYC + 20, t);
        chk("bringup_rst_low_len", 64'(t - rel), 64'(RST_CYC));
        chk_mode("bringup", 2'b10);
        traffic(1'b1, 300, 1'b1);

        // 1000M -> 100M
        do_switch(2'b01, "to100");
        traffic(1'b0, 300, 1'b1);

        // Glitch towards 1000M shorter than the stability window
        watch_en = 3'b010;
        low0 = low_cnt; en0 = en_bad_cnt;
        speed = 2'b10;
        repeat (10) tick();
        speed = 2'b01;
        repeat (150) tick();
        chk("glitch_e_rst_n_low_cycles", 64'(low_cnt - low0), 64'(0));
        chk("glitch_enable_changes", 64'(en_bad_cnt - en0), 64'(0));

        // Reserved code while running, traffic must keep flowing
        low0 = low_cnt; en0 = en_bad_cnt;
        speed = 2'b11;
        traffic(1'b0, 200, 1'b1);
        chk("rsvd_e_rst_n_low_cycles", 64'(low_cnt - low0), 64'(0));
        chk("rsvd_enable_changes", 64'(en_bad_cnt - en0), 64'(0));
        chk_mode("rsvd", 2'b01);
        speed = 2'b01;
        repeat (10) tick();

        // 100M -> 1000M, then a speed change inside a 1000-byte transmit frame
        do_switch(2'b10, "to1000");
        fall = -1;
        for (int i = 0; i < 1000; i++) begin
            logic [DW-1:0] b;
            b = DW'($urandom);
            gmii_tx_en = 1'b1;
            gmii_txd = b;
            txq.push_back('{d: b, due: cyc + 2});
            if (i == 100) speed = 2'b01;
            tick();
            if (e_rst_n !== 1'b1 && fall < 0) fall = cyc;
        end
        c_last = cyc - 1;
        idle();
        for (int i = 0; i < 20 && fall < 0; i++) begin
            tick();
            if (e_rst_n !== 1'b1) fall = cyc;
        end
        chk_rng("drain_phy_rst_after_frame", fall, c_last + 2, c_last + 4);
        wait_rst(1'b1, RST_CYC + 10, t);
        chk("drain_phy_rst_len", 64'(t - fall), 64'(RST_CYC));
        chk_mode("after_drain", 2'b01);

        // Link loss
        c0 = cyc;
        link = 1'b0;
        wait_rst(1'b0, SYNC_STAGES + 1, t);
        chk_rng("linkdown_e_rst_n_delay", t - c0, 1, SYNC_STAGES + 1);
`ifdef GMII_SPEED_ARBI_LINKDOWN_RST_EN
        chk("linkdown_phy_rst_enables", 64'({eth_1000m_en, eth_100m_en, eth_10m_en}), 64'(0));
        c0 = cyc;
        link = 1'b1;
        wait_rst(1'b1, RST_CYC + SYNC_STAGES + 10, t);
        chk_rng("linkup_phy_rst_len", t - c0, RST_CYC - SYNC_STAGES - 2, RST_CYC + SYNC_STAGES + 2);
        chk_mode("linkup", 2'b01);
`else
        repeat (30) tick();
        chk_mode("linkdown_still_run", 2'b01);
        chk("linkdown_e_rst_n_held", 64'(e_rst_n), 64'(0));
        c0 = cyc;
        link = 1'b1;
        wait_rst(1'b1, SYNC_STAGES + 2, t);
        chk_rng("linkup_e_rst_n_delay", t - c0, 1, SYNC_STAGES + 2);
        chk_mode("linkup", 2'b01);
`endif

        // Reset in the middle of traffic aborts at once
        traffic(1'b0, 40, 1'b0);
        idle();
        rst_n = 1'b0;
        speed = 2'b10;
        tick();
        txq.delete();
        rxq.delete();
        chk("midreset_e_tx_en_r", 64'(e_tx_en_r), 64'(0));
        chk("midreset_e_rx_dv", 64'(e_rx_dv), 64'(0));
        chk("midreset_e_rst_n", 64'(e_rst_n), 64'(0));
        chk("midreset_ticks", 64'(pack_total_len), 64'(T10));
        repeat (3) tick();
        rel = cyc;
        rst_n = 1'b1;
        wait_rst(1'b1, RST_CYC + 20, t);
        chk("midreset_rst_low_len", 64'(t - rel), 64'(RST_CYC));
        chk_mode("midreset_rerun", 2'b10);
        traffic(1'b1, 150, 1'b1);

        repeat (4) tick();
        chk("txq_drained", 64'(txq.size()), 64'(0));
        chk("rxq_drained", 64'(rxq.size()), 64'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/gmii_speed_arbi.md
GMII_SPEED_ARBI -- requirements
Module: gmii_speed_arbi

Interface
REQ-001 DATA_W, 8, GMII data width; all data ports use it.
REQ-002 SYNC_STAGES, 3, synchroniser depth for speed and link; minimum 2.
REQ-003 STABLE_CYC, 64, cycles that synchronised speed must hold unchanged before a switch is accepted.
REQ-004 RST_CYC, 200, PHY reset low pulse length in cycles.
REQ-005 TICKS_1000 / TICKS_100 / TICKS_10, 125000000 / 25000000 / 2500000, per-second tick counts reported on pack_total_len.
REQ-006 clk  in  1  single clock for all logic.
REQ-007 rst_n  in  1  reset, synchronous, active-low.
REQ-008 speed  in  2  async PHY speed code: 10=1000M, 01=100M, 00=10M, 11=reserved.
REQ-009 link  in  1  async PHY link status.
REQ-010 gmii_rx_dv_r / gmii_rxd_r  in  1 / DATA_W  raw PHY receive pins.
REQ-011 gmii_tx_en / gmii_txd  in  1 / DATA_W  MAC transmit.
REQ-012 e10_100_rx_dv / e10_100_rxd  in  1 / DATA_W  receive data from the 10/100 rx buffer.
REQ-013 e10_100_tx_en / e10_100_txd  in  1 / DATA_W  transmit data from the 10/100 tx buffer.
REQ-014 rx_dv_raw / rxd_raw  out  1 / DATA_W  registered PHY receive, ungated, for the rx buffer.
REQ-015 eth_1000m_en / eth_100m_en / eth_10m_en  out  1 each  one-hot active mode, all 0 outside RUN.
REQ-016 pack_total_len  out  32  tick count of active mode.
REQ-017 e_rst_n  out  1  PHY reset, active-low.
REQ-018 e_rx_dv / e_rxd  out  1 / DATA_W  receive to MAC.
REQ-019 e_tx_en_r / e_txd_r  out  1 / DATA_W  transmit to PHY, IOB-packed registers.

Function
REQ-020 FSM states PHY_RST, RUN, SETTLE, DRAIN; speed_cur holds accepted mode.
REQ-021 PHY_RST: e_rst_n=0, counter runs; at count RST_CYC-1 -> RUN, speed_cur <= synchronised speed (11 maps to 10M).
REQ-022 RUN: synchronised speed differing from speed_cur and not 11 -> SETTLE, counter cleared; code 11 ignored.
REQ-023 SETTLE: any change of synchronised speed restarts counter; value equal to speed_cur -> RUN; STABLE_CYC consecutive unchanged cycles -> DRAIN.
REQ-024 DRAIN: leave only when rx_dv_raw=0 and gmii_tx_en=0 in same cycle -> PHY_RST; no frame cut mid-packet.
REQ-025 Mode enables and pack_total_len driven from speed_cur in RUN, SETTLE, DRAIN; pack_total_len=TICKS_10 in PHY_RST.
REQ-026 Mux: 1000M selects registered gmii path, 10/100 selects e10_100 inputs; in PHY_RST e_rx_dv=0, e_tx_en_r=0.
REQ-027 Latency: gmii_rx_dv_r -> e_rx_dv 2 cycles; gmii_tx_en -> e_tx_en_r 2 cycles; e10_100_* -> outputs 1 cycle (e_rx_dv) / 2 cycles (e_tx_en_r).
REQ-028 e_rst_n = link_sync AND (state != PHY_RST), registered.
REQ-029 Counter 16 bits, saturates, never wraps.

Reset
REQ-030 rst_n=0 at clk edge: state PHY_RST, counter 0, speed_cur=00, synchronisers 0, all outputs 0, pack_total_len=TICKS_10.
REQ-031 rst_n asserted mid-frame aborts immediately; no drain.

Configuration
REQ-032 GMII_SPEED_ARBI_LINKDOWN_RST_EN defined: link_sync falling in any state other than PHY_RST -> PHY_RST, counter 0; undefined: link only gates e_rst_n per REQ-028.

Structure
REQ-033 Package gmii_arbi_pkg: speed code constants, FSM state enum, default tick constants.
REQ-034 Sub-module gmii_sync: parametrised SYNC_STAGES flop chain, instantiated for speed and link.

Verification
REQ-035 Reset release, speed=10, link=1 -> e_rst_n low 200 cycles then high; eth_1000m_en=1; pack_total_len=125000000.
REQ-036 RUN 1000M, speed->01 held -> after SYNC_STAGES+64 cycles DRAIN; PHY_RST 200 cycles; eth_100m_en=1; pack_total_len=25000000.
REQ-037 speed glitch 10->01 for 10 cycles then back -> no state leaves SETTLE into DRAIN; e_rst_n stays high.
REQ-038 speed change during 1000-byte tx frame -> PHY_RST entered only after gmii_tx_en falls; frame bytes intact at e_txd_r with 2-cycle latency.
REQ-039 speed=11 in RUN -> no transition, outputs unchanged.
REQ-040 With macro, link 1->0 in RUN -> PHY_RST within SYNC_STAGES+1 cycles; without macro, state stays RUN, e_rst_n=0.
